// File: rtl/ddr3_ba_delay_step_ctrl.sv
// Bank-address IOD delay-line sequencer: turns absolute per-lane tap requests
// into LOAD / MOVE / DIRECTION pulse trains and tracks each lane's current tap.

module ddr3_ba_delay_step_lane #(
   parameter int TAP_W       = 8,
   parameter int DEFAULT_TAP = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             nxt_move,
   input  logic             nxt_load,
   input  logic             nxt_dir,
   input  logic             tap_en,
   input  logic             tap_inc,
   input  logic             tap_rld,
   output logic [TAP_W-1:0] tap,
   output logic             move,
   output logic             load,
   output logic             dir
);

   always_ff @(posedge clk) begin
      if (rst) begin
         tap  <= TAP_W'(DEFAULT_TAP);
         move <= 1'b0;
         load <= 1'b0;
         dir  <= 1'b0;
      end else begin
         move <= nxt_move;
         load <= nxt_load;
         dir  <= nxt_dir;
         if (tap_rld)
            tap <= TAP_W'(DEFAULT_TAP);
         else if (tap_en)
            tap <= tap_inc ? tap + TAP_W'(1) : tap - TAP_W'(1);
      end
   end

endmodule

module ddr3_ba_delay_step_ctrl #(
   parameter int NUM_LANES     = 3,
   parameter int TAP_W         = 8,
   parameter int DEFAULT_TAP   = 1,
   parameter int MAX_TAP       = 255,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                       FAB_CLK,
   input  logic                       TX_SYNC_RST,
   input  logic                       REQ_VALID,
   output logic                       REQ_READY,
   input  logic [1:0]                 REQ_LANE,
   input  logic                       REQ_LOAD,
   input  logic [TAP_W-1:0]           REQ_TAP,
   output logic                       RESP_ACK,
   output logic                       RESP_ERR,
   output logic                       BUSY,
   output logic [NUM_LANES*TAP_W-1:0] CUR_TAP,
   output logic [NUM_LANES-1:0]       DELAY_LINE_LOAD,
   output logic [NUM_LANES-1:0]       DELAY_LINE_MOVE,
   output logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION,
   input  logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE
);

   localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
   // One spare bit so the range check stays meaningful when MAX_TAP is the full counter range
   localparam logic [TAP_W:0] MAX_X = (TAP_W + 1)'(MAX_TAP);

   typedef enum logic [2:0] {IDLE, SETUP, STEP, GAP, LOAD, DONE} state_t;

   state_t                             state, nxt_state;
   logic [1:0]                         lane_q, nxt_lane, cmd_lane;
   logic [TAP_W-1:0]                   target_q, nxt_target;
   logic                               load_q, nxt_load_q;
   logic                               dir_q, nxt_dir_q;
   logic                               err_q, nxt_err;
   logic [CNT_W-1:0]                   cnt, nxt_cnt;
   logic [NUM_LANES-1:0]               sel;
   logic [NUM_LANES-1:0][TAP_W-1:0]    taps;
   logic [TAP_W-1:0]                   cur_sel, stepped;
   logic                               oor_sel, req_bad;
   logic                               tap_en, tap_rld;
   logic                               move_on, load_on, dir_on;

   // While idle the incoming request picks the lane so the first registered pulse lands on it
   assign cmd_lane = (state == IDLE) ? REQ_LANE : lane_q;

   always_comb begin
      sel     = '0;
      cur_sel = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (cmd_lane == 2'(i)) begin
            sel[i]  = 1'b1;
            cur_sel = taps[i];
         end
      end
   end

   assign oor_sel = |(DELAY_LINE_OUT_OF_RANGE & sel);
   assign stepped = dir_q ? cur_sel + TAP_W'(1) : cur_sel - TAP_W'(1);
   assign req_bad = (32'(REQ_LANE) >= 32'(NUM_LANES)) ||
                    (!REQ_LOAD && ({1'b0, REQ_TAP} > MAX_X));

   always_comb begin
      nxt_state  = state;
      nxt_lane   = lane_q;
      nxt_target = target_q;
      nxt_load_q = load_q;
      nxt_dir_q  = dir_q;
      nxt_err    = err_q;
      nxt_cnt    = cnt;
      tap_en     = 1'b0;
      tap_rld    = 1'b0;
      case (state)
         IDLE: begin
            if (REQ_VALID && REQ_READY) begin
               nxt_lane   = REQ_LANE;
               nxt_target = REQ_TAP;
               nxt_load_q = REQ_LOAD;
               nxt_dir_q  = 1'b0;
               nxt_err    = 1'b0;
               if (req_bad) begin
                  nxt_err   = 1'b1;
                  nxt_state = DONE;
               end else if (REQ_LOAD) begin
                  nxt_state = LOAD;
               end else if (REQ_TAP == cur_sel) begin
                  nxt_state = DONE;
               end else begin
                  nxt_dir_q = (REQ_TAP > cur_sel);
                  nxt_state = SETUP;
               end
            end
         end
         SETUP: nxt_state = STEP;
         STEP, LOAD: begin
            nxt_cnt   = CNT_W'(SETTLE_CYCLES);
            nxt_state = GAP;
         end
         GAP: begin
            if (cnt == CNT_W'(1)) begin
               if (load_q) begin
                  tap_rld   = 1'b1;
                  nxt_err   = oor_sel;
                  nxt_state = DONE;
               end else if (oor_sel) begin
                  nxt_err   = 1'b1;
                  nxt_state = DONE;
               end else begin
                  tap_en    = 1'b1;
                  nxt_state = (stepped == target_q) ? DONE : STEP;
               end
            end else begin
               nxt_cnt = cnt - CNT_W'(1);
            end
         end
         DONE:    nxt_state = IDLE;
         default: nxt_state = IDLE;
      endcase
   end

   // Pulse outputs are decoded from the next state and registered in the lanes
   assign move_on = (nxt_state == STEP);
   assign load_on = (nxt_state == LOAD);
   assign dir_on  = nxt_dir_q &&
                    ((nxt_state == SETUP) || (nxt_state == STEP) || (nxt_state == GAP));

   always_ff @(posedge FAB_CLK) begin
      if (TX_SYNC_RST) begin
         state     <= IDLE;
         lane_q    <= '0;
         target_q  <= '0;
         load_q    <= 1'b0;
         dir_q     <= 1'b0;
         err_q     <= 1'b0;
         cnt       <= '0;
         REQ_READY <= 1'b1;
         BUSY      <= 1'b0;
         RESP_ACK  <= 1'b0;
         RESP_ERR  <= 1'b0;
      end else begin
         state     <= nxt_state;
         lane_q    <= nxt_lane;
         target_q  <= nxt_target;
         load_q    <= nxt_load_q;
         dir_q     <= nxt_dir_q;
         err_q     <= nxt_err;
         cnt       <= nxt_cnt;
         REQ_READY <= (nxt_state == IDLE);
         BUSY      <= (nxt_state != IDLE);
         RESP_ACK  <= (nxt_state == DONE);
         RESP_ERR  <= (nxt_state == DONE) && nxt_err;
      end
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      ddr3_ba_delay_step_lane #(
         .TAP_W       (TAP_W),
         .DEFAULT_TAP (DEFAULT_TAP)
      ) u_lane (
         .clk      (FAB_CLK),
         .rst      (TX_SYNC_RST),
         .nxt_move (move_on & sel[i]),
         .nxt_load (load_on & sel[i]),
         .nxt_dir  (dir_on & sel[i]),
         .tap_en   (tap_en & sel[i]),
         .tap_inc  (dir_q),
         .tap_rld  (tap_rld & sel[i]),
         .tap      (taps[i]),
         .move     (DELAY_LINE_MOVE[i]),
         .load     (DELAY_LINE_LOAD[i]),
         .dir      (DELAY_LINE_DIRECTION[i])
      );
      assign CUR_TAP[i*TAP_W +: TAP_W] = taps[i];
   end

endmodule

// File: tb/tb_ddr3_ba_delay_step_ctrl.sv
// Bench for ddr3_ba_delay_step_ctrl: request table, ACK scoreboard, pulse monitor.

module tb_ddr3_ba_delay_step_ctrl;

   localparam int NL = 3;
   localparam int TW = 8;
   localparam int S  = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic [1:0]        req_lane = '0;
   logic              req_load = 1'b0;
   logic [TW-1:0]     req_tap = '0;
   logic              resp_ack, resp_err, busy;
   logic [NL*TW-1:0]  cur_tap;
   logic [NL-1:0]     dl_load, dl_move, dl_dir;
   logic [NL-1:0]     oor = '0;

   always #5 clk = ~clk;

   ddr3_ba_delay_step_ctrl #(
      .NUM_LANES(NL), .TAP_W(TW), .DEFAULT_TAP(1), .MAX_TAP(255), .SETTLE_CYCLES(S)
   ) dut (
      .FAB_CLK                 (clk),
      .TX_SYNC_RST             (rst),
      .REQ_VALID               (req_valid),
      .REQ_READY               (req_ready),
      .REQ_LANE                (req_lane),
      .REQ_LOAD                (req_load),
      .REQ_TAP                 (req_tap),
      .RESP_ACK                (resp_ack),
      .RESP_ERR                (resp_err),
      .BUSY                    (busy),
      .CUR_TAP                 (cur_tap),
      .DELAY_LINE_LOAD         (dl_load),
      .DELAY_LINE_MOVE         (dl_move),
      .DELAY_LINE_DIRECTION    (dl_dir),
      .DELAY_LINE_OUT_OF_RANGE (oor)
   );

   typedef struct {
      int lane; bit load; int tap; int oor_step;
      bit exp_err; int exp_lat; int exp_tap; int exp_moves; int exp_loads; int exp_dir;
   } vec_t;

   typedef struct { int cyc; bit err; } sb_t;

   sb_t  sb[$];
   vec_t vecs[10];
   int   tests = 0, fails = 0, cyc = 0;
   int   act_lane = -1, mv_cnt = 0, ld_cnt = 0, dir_cnt = 0, stray = 0;
   int   first_mv = -1, first_ld = -1, last_mv = 0, ack_cnt = 0;
   int   model[NL];

   function automatic void check(string name, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor and ACK scoreboard
   always @(negedge clk) begin
      for (int i = 0; i < NL; i++) begin
         if (dl_move[i]) begin
            if (i == act_lane) begin
               mv_cnt++;
               if (mv_cnt == 1) first_mv = cyc;
               else check("move_spacing", cyc - last_mv, S + 1);
               last_mv = cyc;
            end else stray++;
         end
         if (dl_load[i]) begin
            if (i == act_lane) begin ld_cnt++; first_ld = cyc; end
            else stray++;
         end
         if (dl_dir[i]) begin
            if (i == act_lane) dir_cnt++;
            else stray++;
         end
      end
      if (resp_ack) begin : pop
         sb_t e;
         ack_cnt++;
         if (sb.size() == 0) check("unexpected_ack", int'(resp_ack), 0);
         else begin
            e = sb.pop_front();
            check("ack_cycle", cyc, e.cyc);
            check("resp_err", int'(resp_err), int'(e.err));
         end
      end
   end

   task automatic clr_counts(input int lane);
      mv_cnt = 0; ld_cnt = 0; dir_cnt = 0; stray = 0;
      first_mv = -1; first_ld = -1; ack_cnt = 0; act_lane = lane;
   endtask

   task automatic check_taps();
      for (int i = 0; i < NL; i++)
         check($sformatf("cur_tap%0d", i), int'(cur_tap[i*TW +: TW]), model[i]);
   endtask

   task automatic run_vec(input vec_t v);
      int   t0, budget;
      sb_t  e;
      clr_counts(v.lane);
      budget = 50;
      @(negedge clk);
      while (!req_ready && budget > 0) begin @(negedge clk); budget--; end
      check("ready_wait", int'(req_ready), 1);
      req_valid = 1'b1;
      req_lane  = v.lane[1:0];
      req_load  = v.load;
      req_tap   = v.tap[TW-1:0];
      t0        = cyc;
      e.cyc = t0 + v.exp_lat;
      e.err = v.exp_err;
      sb.push_back(e);
      if (v.load && v.oor_step != 0) oor[v.lane] = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      if (!v.load && v.oor_step != 0) begin
         budget = 2000;
         while (mv_cnt < v.oor_step && budget > 0) begin @(negedge clk); budget--; end
         oor[v.lane] = 1'b1;
      end
      budget = v.exp_lat + 20;
      while (ack_cnt == 0 && budget > 0) begin @(negedge clk); budget--; end
      check("ack_seen", ack_cnt, 1);
      oor = '0;
      if (v.lane < NL) model[v.lane] = v.exp_tap;
      @(negedge clk);
      check("moves", mv_cnt, v.exp_moves);
      check("loads", ld_cnt, v.exp_loads);
      check("dir_cycles", dir_cnt, v.exp_dir);
      check("stray_pulses", stray, 0);
      check("sb_empty", sb.size(), 0);
      if (v.exp_moves > 0) check("first_move", first_mv, t0 + 2);
      if (v.exp_loads > 0) check("load_cycle", first_ld, t0 + 1);
      check_taps();
   endtask

   initial begin
      int   budget;
      vec_t v;
      //          lane load tap oor err lat  tap moves loads dir
      vecs[0] = '{1, 0,   4,  0, 0,  17,   4,   3,  0,  16};
      vecs[1] = '{0, 0,   3,  0, 0,  12,   3,   2,  0,  11};
      vecs[2] = '{0, 0,   0,  0, 0,  17,   0,   3,  0,   0};
      vecs[3] = '{0, 1,  77,  0, 0,   6,   1,   0,  1,   0};
      vecs[4] = '{2, 0,  10,  5, 1,  27,   5,   5,  0,  26};
      vecs[5] = '{3, 0,   0,  0, 1,   1,   0,   0,  0,   0};
      vecs[6] = '{2, 0,   5,  0, 0,   1,   5,   0,  0,   0};
      vecs[7] = '{2, 1,   0,  1, 1,   6,   1,   0,  1,   0};
      vecs[8] = '{1, 0, 255,  0, 0, 1257, 255, 251, 0, 1256};
      vecs[9] = '{2, 0,   0,  0, 0,   7,   0,   1,  0,   0};
      for (int i = 0; i < NL; i++) model[i] = 1;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_ready", int'(req_ready), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_ack", int'(resp_ack), 0);
      check("rst_pulses", int'({dl_move, dl_load, dl_dir}), 0);
      check_taps();

      for (int i = 0; i < 10; i++) run_vec(vecs[i]);

      // Reset in the middle of a six-step move on lane 0 (currently at tap 1)
      clr_counts(0);
      @(negedge clk);
      req_valid = 1'b1; req_lane = 2'd0; req_load = 1'b0; req_tap = 8'd7;
      @(negedge clk);
      req_valid = 1'b0;
      budget = 100;
      while (mv_cnt < 2 && budget > 0) begin @(negedge clk); budget--; end
      check("rst_mid_two_moves", mv_cnt, 2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < NL; i++) model[i] = 1;
      check("mid_rst_ready", int'(req_ready), 1);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_pulses", int'({dl_move, dl_load, dl_dir}), 0);
      check_taps();
      repeat (40) @(negedge clk);
      check("mid_rst_no_more_moves", mv_cnt, 2);
      check("mid_rst_no_ack", ack_cnt, 0);

      v = '{1, 0, 3, 0, 0, 12, 3, 2, 0, 11};
      run_vec(v);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
